// File: rtl/vtx_packet_loader.sv
// rtl/vtx_packet_loader.sv - assembles framed UART bytes into triangle coords, committed at frame start
// Optional trailing XOR checksum byte is enabled by defining VTX_LOADER_CHECKSUM_EN.
module vtx_packet_loader #(
   parameter int         NUM_COORDS  = 6,
   parameter int         COORD_W     = 16,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 1048575
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [7:0]                      rx_data,
   input  logic                            rx_done,
   input  logic                            frame_start,
   output logic [NUM_COORDS*COORD_W-1:0]   coords_out,
   output logic                            pending,
   output logic                            pkt_ok,
   output logic                            pkt_err
);
   localparam int TOTAL_W = NUM_COORDS * COORD_W;
   localparam int NBYTES  = TOTAL_W / 8;
   localparam int CNT_W   = $clog2(NBYTES + 1);
   localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

`ifdef VTX_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, ACCEPT} state_t;
`else
   typedef enum logic [1:0] {IDLE, PAYLOAD, ACCEPT} state_t;
`endif

   state_t               state;
   logic [TOTAL_W-1:0]   staging;
   logic [TOTAL_W-1:0]   shadow;
   logic [CNT_W-1:0]     cnt;
   logic [TO_W-1:0]      tcnt;
   logic                 timed_out;
`ifdef VTX_LOADER_CHECKSUM_EN
   logic [7:0]           chk_acc;
`endif

   // Fires on the TIMEOUT_CYC-th consecutive cycle without a byte inside a packet.
   assign timed_out = !rx_done && (tcnt == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         staging    <= '0;
         shadow     <= '0;
         coords_out <= '0;
         pending    <= 1'b0;
         pkt_ok     <= 1'b0;
         pkt_err    <= 1'b0;
         cnt        <= '0;
         tcnt       <= '0;
`ifdef VTX_LOADER_CHECKSUM_EN
         chk_acc    <= '0;
`endif
      end else begin
         pkt_ok  <= 1'b0;
         pkt_err <= 1'b0;

         // Commit uses pre-edge shadow/pending; a same-cycle ACCEPT below re-arms pending.
         if (frame_start && pending) begin
            coords_out <= shadow;
            pending    <= 1'b0;
         end

         if ((state != IDLE) && (state != ACCEPT) && !rx_done)
            tcnt <= tcnt + 1'b1;
         else
            tcnt <= '0;

         case (state)
            IDLE: begin
               cnt <= '0;
`ifdef VTX_LOADER_CHECKSUM_EN
               chk_acc <= '0;
`endif
               if (rx_done && (rx_data == SYNC_BYTE))
                  state <= PAYLOAD;
            end
            PAYLOAD: begin
               if (rx_done) begin
                  staging[{cnt, 3'b000} +: 8] <= rx_data;
                  cnt <= cnt + 1'b1;
`ifdef VTX_LOADER_CHECKSUM_EN
                  chk_acc <= chk_acc ^ rx_data;
                  if (cnt == LAST_IDX)
                     state <= CHECK;
`else
                  if (cnt == LAST_IDX)
                     state <= ACCEPT;
`endif
               end else if (timed_out) begin
                  pkt_err <= 1'b1;
                  state   <= IDLE;
                  cnt     <= '0;
                  tcnt    <= '0;
               end
            end
`ifdef VTX_LOADER_CHECKSUM_EN
            CHECK: begin
               if (rx_done) begin
                  if (rx_data == chk_acc) begin
                     state <= ACCEPT;
                  end else begin
                     pkt_err <= 1'b1;
                     state   <= IDLE;
                     cnt     <= '0;
                  end
               end else if (timed_out) begin
                  pkt_err <= 1'b1;
                  state   <= IDLE;
                  cnt     <= '0;
                  tcnt    <= '0;
               end
            end
`endif
            ACCEPT: begin
               shadow  <= staging;
               pending <= 1'b1;
               pkt_ok  <= 1'b1;
               state   <= IDLE;
               cnt     <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vtx_packet_loader.sv
// tb/tb_vtx_packet_loader.sv - scoreboard bench for vtx_packet_loader with coordinate-level model
// Honours VTX_LOADER_CHECKSUM_EN the same way as the design.
module tb_vtx_packet_loader;
   localparam int NC = 6;
   localparam int CW = 16;
   localparam int NB = NC * CW / 8;
   localparam int TO = 50;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_done = 1'b0;
   logic              frame_start = 1'b0;
   logic [NC*CW-1:0]  coords_out;
   logic              pending;
   logic              pkt_ok;
   logic              pkt_err;

   vtx_packet_loader #(
      .NUM_COORDS(NC), .COORD_W(CW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .frame_start(frame_start), .coords_out(coords_out), .pending(pending),
      .pkt_ok(pkt_ok), .pkt_err(pkt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NC*CW-1:0] coords;
      logic             pend;
   } cchk_t;

   int    total = 0;
   int    bad = 0;
   bit    evq[$];
   cchk_t cq[$];
   int    shadow_m[NC];
   int    coords_m[NC];
   bit    pend_m;
   logic  fs_q = 1'b0;

   function automatic logic [NC*CW-1:0] pack_coords(input int c[NC]);
      logic [NC*CW-1:0] r;
      r = '0;
      for (int k = 0; k < NC; k++) r[k*CW +: CW] = c[k][CW-1:0];
      return r;
   endfunction

   always @(posedge clk) fs_q <= frame_start;

   always @(negedge clk) begin : monitor
      bit    e;
      cchk_t c;
      if (!reset) begin
         if (pkt_ok || pkt_err) begin
            total++;
            if (evq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event: got ok=%0b err=%0b, none expected", pkt_ok, pkt_err);
            end else begin
               e = evq.pop_front();
               if (pkt_ok !== e || pkt_err !== !e) begin
                  bad++;
                  $display("FAIL pkt_event: got ok=%0b err=%0b expected ok=%0b err=%0b",
                           pkt_ok, pkt_err, e, !e);
               end
            end
         end
         if (fs_q) begin
            total++;
            if (cq.size() == 0) begin
               bad++;
               $display("FAIL commit_unexpected: frame_start with no expectation queued");
            end else begin
               c = cq.pop_front();
               if (coords_out !== c.coords || pending !== c.pend) begin
                  bad++;
                  $display("FAIL commit: got coords=%h pending=%0b expected coords=%h pending=%0b",
                           coords_out, pending, c.coords, c.pend);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
   endtask

   task automatic model_commit();
      cchk_t c;
      if (pend_m) begin
         coords_m = shadow_m;
         pend_m = 1'b0;
      end
      c.coords = pack_coords(coords_m);
      c.pend = pend_m;
      cq.push_back(c);
   endtask

   task automatic frame();
      model_commit();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // chk_delta != 0 corrupts the checksum (ignored when no checksum byte is sent).
   task automatic send_packet(input int c[NC], input int gap_max, input logic [7:0] chk_delta,
                              input bit fs_at_accept);
      logic [7:0] b;
      logic [7:0] x;
      bit         good;
      cchk_t      cc;
      x = 8'h00;
`ifdef VTX_LOADER_CHECKSUM_EN
      good = (chk_delta == 8'h00);
`else
      good = 1'b1;
`endif
      evq.push_back(good);
      send_byte(8'hA5, gap_max);
      for (int k = 0; k < NC; k++)
         for (int j = 0; j < CW / 8; j++) begin
            b = 8'((c[k] >> (8 * j)) & 255);
            x = x ^ b;
            if (k == NC - 1 && j == CW / 8 - 1) send_byte(b, 0);
            else send_byte(b, gap_max);
         end
`ifdef VTX_LOADER_CHECKSUM_EN
      send_byte(x ^ chk_delta, 0);
`endif
      if (fs_at_accept) begin
         if (pend_m) coords_m = shadow_m;
         if (good) begin
            shadow_m = c;
            pend_m = 1'b1;
         end else begin
            pend_m = 1'b0;
         end
         cc.coords = pack_coords(coords_m);
         cc.pend = pend_m;
         cq.push_back(cc);
         frame_start = 1'b1;
      end else if (good) begin
         shadow_m = c;
         pend_m = 1'b1;
      end
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic reset_model();
      for (int k = 0; k < NC; k++) begin
         shadow_m[k] = 0;
         coords_m[k] = 0;
      end
      pend_m = 1'b0;
   endtask

   task automatic check_reset_state();
      check("reset_coords", coords_out, '0);
      check("reset_pending", {95'd0, pending}, '0);
      check("reset_pkt_ok", {95'd0, pkt_ok}, '0);
      check("reset_pkt_err", {95'd0, pkt_err}, '0);
   endtask

   int pa[NC];
   int pb[NC];

   initial begin
      reset_model();
      reset = 1'b1;
      repeat (3) tick();
      check_reset_state();
      reset = 1'b0;
      tick();

      pa = '{1, 2, 3, 4, 5, 6};
      send_packet(pa, 0, 8'h00, 1'b0);
      check("pending_after_ok", {95'd0, pending}, 96'd1);
      frame();
      tick();
      check("pending_after_commit", {95'd0, pending}, '0);

`ifdef VTX_LOADER_CHECKSUM_EN
      pb = '{11, 12, 13, 14, 15, 16};
      send_packet(pb, 1, 8'h0F, 1'b0);
      check("pending_after_bad_chk", {95'd0, pending}, '0);
      frame();
`endif

      evq.push_back(1'b0);
      send_byte(8'hA5, 0);
      for (int i = 0; i < 3; i++) send_byte(8'h33, 0);
      repeat (TO + 5) tick();
      send_byte(8'h11, 0);
      repeat (3) tick();
      for (int k = 0; k < NC; k++) pa[k] = 100 * k - 250;
      send_packet(pa, 1, 8'h00, 1'b0);
      frame();

      pa = '{32767, -32768, 16'shA5A5, -1, 0, 255};
      send_packet(pa, 2, 8'h00, 1'b0);
      frame();

      for (int k = 0; k < NC; k++) pa[k] = 7 * k + 1000;
      for (int k = 0; k < NC; k++) pb[k] = -9 * k - 3;
      send_packet(pa, 0, 8'h00, 1'b0);
      send_packet(pb, 0, 8'h00, 1'b1);
      check("pending_after_accept_commit", {95'd0, pending}, 96'd1);
      frame();
      frame();

      for (int k = 0; k < NC; k++) pa[k] = 42 + k;
      for (int k = 0; k < NC; k++) pb[k] = -42 - k;
      send_packet(pa, 1, 8'h00, 1'b0);
      send_packet(pb, 1, 8'h00, 1'b0);
      frame();

      send_byte(8'hA5, 0);
      for (int i = 0; i < 5; i++) send_byte(8'h5A, 0);
      reset = 1'b1;
      tick();
      check_reset_state();
      reset = 1'b0;
      reset_model();
      tick();
      for (int k = 0; k < NC; k++) pa[k] = 3000 - k;
      send_packet(pa, 1, 8'h00, 1'b0);
      frame();

      for (int it = 0; it < 40; it++) begin
         logic [7:0] g;
         logic [7:0] delta;
         for (int k = 0; k < NC; k++) pa[k] = int'($urandom_range(0, 65535)) - 32768;
         repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1);
         end
         delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_packet(pa, 2, delta, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) frame();
      end
      frame();

      repeat (5) tick();
      check("events_drained", 96'(evq.size()), '0);
      check("commits_drained", 96'(cq.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
